reservation_station_am: RTL and testbench
=========================================

# reservation_station_am

Parametrised age-matrix reservation station with a registered issue stage. It replaces the counter-aged station between dispatch and each functional unit. Sources are woken from any number of CDBs, and the oldest ready entry is issued through a valid/stall output register. Width, depth, source count and CDB count are all configurable.

## Interface
- RS_DEPTH, 8: slot count; power of two, ≥2
- CDB_DEPTH, 2: CDB count
- SRC_CNT, 2: source operands per entry (1..3)
- DATA_W, 32: operand/insn width
- ADDR_W, 32: iaddr width
- TAG_W, 6: tag width
- OPCODE_W, 5: opcode width
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- i_flush  in  1  discard all contents
- i_cdb_en / i_cdb_data / i_cdb_tag  in  [CDB_DEPTH] x 1 / DATA_W / TAG_W  broadcast valid, data, tag
- i_rs_en  in  1  dispatch request
- i_rs_opcode / i_rs_iaddr / i_rs_insn  in  OPCODE_W / ADDR_W / DATA_W  dispatched op
- i_rs_src_tag / i_rs_src_data / i_rs_src_rdy  in  [SRC_CNT] x TAG_W / DATA_W / 1  source state
- i_rs_dst_tag  in  TAG_W  destination tag
- o_rs_stall  out  1  no free slot
- i_fu_stall  in  1  FU cannot accept output register
- o_fu_valid  out  1  output register valid
- o_fu_opcode / o_fu_iaddr / o_fu_insn / o_fu_tag  out  per widths above  issued op
- o_fu_src_data  out  [SRC_CNT] x DATA_W  issued operands

## Operation
- Slot state: valid bit, payload, per-source rdy/tag/data. Age is an RS_DEPTH x RS_DEPTH bit matrix: older[i][j] = 1 means slot i is older than slot j.
- Dispatch accepted when i_rs_en & ~o_rs_stall. The target is the lowest-index empty slot.
  - Write row k = 0 and column k = 1 for all other slots, so the new entry is youngest.
  - Per source: a matching CDB in the dispatch cycle overrides i_rs_src_* (rdy=1, data=CDB). Sources already rdy are never overwritten.
- Wakeup: valid & ~rdy & cdb_en & tag match sets rdy and captures data. If several CDBs match, the highest index wins.
- Ready = valid & all SRC_CNT rdy. Select = ready & no other ready slot j with older[j][i]. At most one slot is selected.
- Issue fires when some slot is selected & (~o_fu_valid | ~i_fu_stall).
  - Selected payload loads into the output register; the slot's valid is cleared.
  - Stale matrix bits are masked by valid.
- Output register: held unchanged while o_fu_valid & i_fu_stall. It clears when consumed with no new issue.
- o_rs_stall = all slots valid. It is computed from registered state; a slot freed by issue is usable the next cycle.
- Flush has the highest priority: all valid bits and o_fu_valid clear next cycle. Dispatch, wakeup and issue in that cycle are dropped.

## Timing
- Reset: all slots empty, o_fu_valid=0, o_rs_stall=0, all o_fu_* data outputs=0.
- Dispatch with all sources rdy in cycle N: selectable in N+1, o_fu_valid in N+2.
- Last source broadcast in cycle N: rdy in N+1, o_fu_valid in N+2 (N+1 with bypass; see Configuration).
- Dispatch and issue in the same cycle are independent; the new entry never issues in its dispatch cycle.
- Full with i_rs_en high: nothing written; the request must be held by the upstream stage.
- Reset mid-operation: same as reset; in-flight contents are discarded.

## Configuration
- RS_WAKEUP_BYPASS_EN defined:
  - A valid slot whose remaining non-rdy sources all match CDBs in cycle N counts as ready in N.
  - Its operand data is muxed from the CDB directly into the output register.
  - Age ordering includes these slots.
- Undefined: ready is computed from registered rdy only, adding one cycle of wakeup-to-issue latency.

## Test plan
- Reset, then dispatch opcode 3 with both sources rdy (data 0x11, 0x22), i_fu_stall=0 -> o_fu_valid=1 two cycles later, src_data {0x11,0x22}, o_rs_stall=0.
- Fill 8 slots (sources waiting on tags 8..1 in dispatch order), then broadcast tags 1..8 together on two CDBs, 2 per cycle -> o_rs_stall=1 with 8 valid; issue order follows dispatch age, not slot index or wakeup order.
- Hold i_fu_stall=1 with 3 ready entries -> output register frozen on the oldest; release -> remaining two issue on consecutive cycles, oldest first.
- Dispatch source tag 5 while CDB0 broadcasts tag 5 / 0xAB in the same cycle -> entry issues with 0xAB and never waits.
- Pre-rdy source on tag 0 while CDB broadcasts tag 0 / 0xFF -> data unchanged.
- Flush with 4 valid entries and o_fu_valid=1 -> next cycle o_fu_valid=0, o_rs_stall=0; dispatch into slot 0 succeeds.

Source files
------------

// File: rtl/reservation_station_am.sv
// Age-matrix reservation station with a registered issue stage.
// Define RS_WAKEUP_BYPASS_EN to let same-cycle CDB wakeups count towards readiness.
module reservation_station_am #(
    parameter int RS_DEPTH  = 8,
    parameter int CDB_DEPTH = 2,
    parameter int SRC_CNT   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 6,
    parameter int OPCODE_W  = 5
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              i_flush,
    input  logic [CDB_DEPTH-1:0]              i_cdb_en,
    input  logic [CDB_DEPTH-1:0][DATA_W-1:0]  i_cdb_data,
    input  logic [CDB_DEPTH-1:0][TAG_W-1:0]   i_cdb_tag,
    input  logic                              i_rs_en,
    input  logic [OPCODE_W-1:0]               i_rs_opcode,
    input  logic [ADDR_W-1:0]                 i_rs_iaddr,
    input  logic [DATA_W-1:0]                 i_rs_insn,
    input  logic [SRC_CNT-1:0][TAG_W-1:0]     i_rs_src_tag,
    input  logic [SRC_CNT-1:0][DATA_W-1:0]    i_rs_src_data,
    input  logic [SRC_CNT-1:0]                i_rs_src_rdy,
    input  logic [TAG_W-1:0]                  i_rs_dst_tag,
    output logic                              o_rs_stall,
    input  logic                              i_fu_stall,
    output logic                              o_fu_valid,
    output logic [OPCODE_W-1:0]               o_fu_opcode,
    output logic [ADDR_W-1:0]                 o_fu_iaddr,
    output logic [DATA_W-1:0]                 o_fu_insn,
    output logic [TAG_W-1:0]                  o_fu_tag,
    output logic [SRC_CNT-1:0][DATA_W-1:0]    o_fu_src_data
);

    localparam int IDX_W = $clog2(RS_DEPTH);
`ifdef RS_WAKEUP_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic [RS_DEPTH-1:0]                valid;
    logic [OPCODE_W-1:0]                opcode   [RS_DEPTH];
    logic [ADDR_W-1:0]                  iaddr    [RS_DEPTH];
    logic [DATA_W-1:0]                  insn     [RS_DEPTH];
    logic [TAG_W-1:0]                   dst_tag  [RS_DEPTH];
    logic [SRC_CNT-1:0]                 src_rdy  [RS_DEPTH];
    logic [SRC_CNT-1:0][TAG_W-1:0]      src_tag  [RS_DEPTH];
    logic [SRC_CNT-1:0][DATA_W-1:0]     src_data [RS_DEPTH];
    logic [RS_DEPTH-1:0]                older    [RS_DEPTH];

    logic [SRC_CNT-1:0]                 wake_hit  [RS_DEPTH];
    logic [SRC_CNT-1:0][DATA_W-1:0]     wake_data [RS_DEPTH];
    logic [SRC_CNT-1:0]                 disp_hit;
    logic [SRC_CNT-1:0][DATA_W-1:0]     disp_data;
    logic [RS_DEPTH-1:0]                ready;
    logic [RS_DEPTH-1:0]                sel;
    logic [IDX_W-1:0]                   sel_idx;
    logic [IDX_W-1:0]                   free_idx;
    logic [SRC_CNT-1:0][DATA_W-1:0]     iss_data;
    logic                               do_issue;
    logic                               do_disp;

    // CDB match per source; ascending scan lets the highest-index CDB win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        disp_hit  = '0;
        disp_data = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wake_hit[i]  = '0;
            wake_data[i] = '0;
        end
        for (int s = 0; s < SRC_CNT; s++) begin
            for (int c = 0; c < CDB_DEPTH; c++) begin
                if (i_cdb_en[c] && i_cdb_tag[c] == i_rs_src_tag[s]) begin
                    disp_hit[s]  = 1'b1;
                    disp_data[s] = i_cdb_data[c];
                end
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (i_cdb_en[c] && i_cdb_tag[c] == src_tag[i][s]) begin
                        wake_hit[i][s]  = 1'b1;
                        wake_data[i][s] = i_cdb_data[c];
                    end
                end
            end
        end
    end

    // Oldest-ready select: a slot loses if any other ready slot is older than it.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready[i] = valid[i] & (&(src_rdy[i] | (wake_hit[i] & {SRC_CNT{BYPASS}})));
        for (int i = 0; i < RS_DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < RS_DEPTH; j++)
                if (j != i && ready[j] && older[j][i])
                    sel[i] = 1'b0;
            if (sel[i])
                sel_idx = IDX_W'(i);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!valid[i])
                free_idx = IDX_W'(i);
        for (int s = 0; s < SRC_CNT; s++)
            iss_data[s] = (BYPASS && !src_rdy[sel_idx][s]) ? wake_data[sel_idx][s]
                                                          : src_data[sel_idx][s];
    end

    assign o_rs_stall = &valid;
    assign do_issue   = (|sel) & (~o_fu_valid | ~i_fu_stall) & ~i_flush;
    assign do_disp    = i_rs_en & ~o_rs_stall & ~i_flush;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid         <= '0;
            o_fu_valid    <= 1'b0;
            o_fu_opcode   <= '0;
            o_fu_iaddr    <= '0;
            o_fu_insn     <= '0;
            o_fu_tag      <= '0;
            o_fu_src_data <= '0;
        end else if (i_flush) begin
            valid      <= '0;
            o_fu_valid <= 1'b0;
        end else begin
            if (do_issue) begin
                valid[sel_idx] <= 1'b0;
                o_fu_valid     <= 1'b1;
                o_fu_opcode    <= opcode[sel_idx];
                o_fu_iaddr     <= iaddr[sel_idx];
                o_fu_insn      <= insn[sel_idx];
                o_fu_tag       <= dst_tag[sel_idx];
                o_fu_src_data  <= iss_data;
            end else if (!i_fu_stall) begin
                o_fu_valid <= 1'b0;
            end
            if (do_disp)
                valid[free_idx] <= 1'b1;
        end
    end

    // NOTE: slot payload and age matrix carry no reset; every read is qualified by valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++)
            for (int s = 0; s < SRC_CNT; s++)
                if (valid[i] && !src_rdy[i][s] && wake_hit[i][s]) begin
                    src_rdy[i][s]  <= 1'b1;
                    src_data[i][s] <= wake_data[i][s];
                end
        if (do_disp) begin
            opcode[free_idx]  <= i_rs_opcode;
            iaddr[free_idx]   <= i_rs_iaddr;
            insn[free_idx]    <= i_rs_insn;
            dst_tag[free_idx] <= i_rs_dst_tag;
            src_tag[free_idx] <= i_rs_src_tag;
            for (int s = 0; s < SRC_CNT; s++) begin
                src_rdy[free_idx][s]  <= i_rs_src_rdy[s] | disp_hit[s];
                src_data[free_idx][s] <= (!i_rs_src_rdy[s] && disp_hit[s]) ? disp_data[s]
                                                                          : i_rs_src_data[s];
            end
            // New entry is youngest: nothing is younger than it, everything else is older.
            older[free_idx] <= '0;
            for (int j = 0; j < RS_DEPTH; j++)
                if (IDX_W'(j) != free_idx)
                    older[j][free_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reservation_station_am.sv
// Bench for reservation_station_am: directed scenarios plus random traffic against an age-ordered queue model.
module tb_reservation_station_am;

    localparam int RS_DEPTH  = 8;
    localparam int CDB_DEPTH = 2;
    localparam int SRC_CNT   = 2;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 6;
    localparam int OPCODE_W  = 5;

    logic                              clk = 1'b0;
    logic                              n_rst = 1'b0;
    logic                              i_flush = 1'b0;
    logic [CDB_DEPTH-1:0]              i_cdb_en = '0;
    logic [CDB_DEPTH-1:0][DATA_W-1:0]  i_cdb_data = '0;
    logic [CDB_DEPTH-1:0][TAG_W-1:0]   i_cdb_tag = '0;
    logic                              i_rs_en = 1'b0;
    logic [OPCODE_W-1:0]               i_rs_opcode = '0;
    logic [ADDR_W-1:0]                 i_rs_iaddr = '0;
    logic [DATA_W-1:0]                 i_rs_insn = '0;
    logic [SRC_CNT-1:0][TAG_W-1:0]     i_rs_src_tag = '0;
    logic [SRC_CNT-1:0][DATA_W-1:0]    i_rs_src_data = '0;
    logic [SRC_CNT-1:0]                i_rs_src_rdy = '0;
    logic [TAG_W-1:0]                  i_rs_dst_tag = '0;
    logic                              o_rs_stall;
    logic                              i_fu_stall = 1'b0;
    logic                              o_fu_valid;
    logic [OPCODE_W-1:0]               o_fu_opcode;
    logic [ADDR_W-1:0]                 o_fu_iaddr;
    logic [DATA_W-1:0]                 o_fu_insn;
    logic [TAG_W-1:0]                  o_fu_tag;
    logic [SRC_CNT-1:0][DATA_W-1:0]    o_fu_src_data;

    always #5 clk = ~clk;

    reservation_station_am #(
        .RS_DEPTH(RS_DEPTH), .CDB_DEPTH(CDB_DEPTH), .SRC_CNT(SRC_CNT), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OPCODE_W(OPCODE_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
        .i_cdb_en(i_cdb_en), .i_cdb_data(i_cdb_data), .i_cdb_tag(i_cdb_tag),
        .i_rs_en(i_rs_en), .i_rs_opcode(i_rs_opcode), .i_rs_iaddr(i_rs_iaddr), .i_rs_insn(i_rs_insn),
        .i_rs_src_tag(i_rs_src_tag), .i_rs_src_data(i_rs_src_data), .i_rs_src_rdy(i_rs_src_rdy),
        .i_rs_dst_tag(i_rs_dst_tag), .o_rs_stall(o_rs_stall), .i_fu_stall(i_fu_stall),
        .o_fu_valid(o_fu_valid), .o_fu_opcode(o_fu_opcode), .o_fu_iaddr(o_fu_iaddr),
        .o_fu_insn(o_fu_insn), .o_fu_tag(o_fu_tag), .o_fu_src_data(o_fu_src_data)
    );

    typedef struct packed {
        logic [OPCODE_W-1:0]            opcode;
        logic [ADDR_W-1:0]              iaddr;
        logic [DATA_W-1:0]              insn;
        logic [TAG_W-1:0]               dst;
        logic [SRC_CNT-1:0]             rdy;
        logic [SRC_CNT-1:0][TAG_W-1:0]  tag;
        logic [SRC_CNT-1:0][DATA_W-1:0] data;
    } ent_t;

    // Model: entries kept oldest-first; slot numbers are irrelevant to behaviour.
    ent_t q[$];
    logic m_valid = 1'b0;
    ent_t m_out = '0;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit cdb_lookup(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        bit hit = 1'b0;
        d = '0;
        for (int c = 0; c < CDB_DEPTH; c++)
            if (i_cdb_en[c] && i_cdb_tag[c] == t) begin
                hit = 1'b1;
                d   = i_cdb_data[c];
            end
        return hit;
    endfunction

    function automatic bit entry_ready(input ent_t e);
        logic [DATA_W-1:0] d;
        for (int s = 0; s < SRC_CNT; s++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            if (!e.rdy[s] && !cdb_lookup(e.tag[s], d)) return 1'b0;
`else
            if (!e.rdy[s]) return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit full;
        int pick;
        logic [DATA_W-1:0] d;
        ent_t e;
        full = (q.size() == RS_DEPTH);
        if (!n_rst) begin
            q.delete();
            m_valid = 1'b0;
            m_out   = '0;
            return;
        end
        if (i_flush) begin
            q.delete();
            m_valid = 1'b0;
            return;
        end
        pick = -1;
        for (int k = 0; k < q.size(); k++)
            if (pick < 0 && entry_ready(q[k])) pick = k;
        if (pick >= 0 && (!m_valid || !i_fu_stall)) begin
            m_out = q[pick];
            for (int s = 0; s < SRC_CNT; s++)
                if (!m_out.rdy[s] && cdb_lookup(m_out.tag[s], d)) m_out.data[s] = d;
            q.delete(pick);
            m_valid = 1'b1;
        end else if (!i_fu_stall) begin
            m_valid = 1'b0;
        end
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            for (int s = 0; s < SRC_CNT; s++)
                if (!e.rdy[s] && cdb_lookup(e.tag[s], d)) begin
                    e.rdy[s]  = 1'b1;
                    e.data[s] = d;
                end
            q[k] = e;
        end
        if (i_rs_en && !full) begin
            e.opcode = i_rs_opcode;
            e.iaddr  = i_rs_iaddr;
            e.insn   = i_rs_insn;
            e.dst    = i_rs_dst_tag;
            e.tag    = i_rs_src_tag;
            for (int s = 0; s < SRC_CNT; s++) begin
                e.rdy[s]  = i_rs_src_rdy[s];
                e.data[s] = i_rs_src_data[s];
                if (!i_rs_src_rdy[s] && cdb_lookup(i_rs_src_tag[s], d)) begin
                    e.rdy[s]  = 1'b1;
                    e.data[s] = d;
                end
            end
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("fu_valid", 64'(o_fu_valid), 64'(m_valid));
        check("rs_stall", 64'(o_rs_stall), 64'(q.size() == RS_DEPTH));
        if (m_valid) begin
            check("fu_opcode", 64'(o_fu_opcode), 64'(m_out.opcode));
            check("fu_iaddr", 64'(o_fu_iaddr), 64'(m_out.iaddr));
            check("fu_insn", 64'(o_fu_insn), 64'(m_out.insn));
            check("fu_tag", 64'(o_fu_tag), 64'(m_out.dst));
            check("fu_src_data", 64'(o_fu_src_data), 64'(m_out.data));
        end
    endtask

    task automatic idle();
        i_rs_en  = 1'b0;
        i_cdb_en = '0;
        i_flush  = 1'b0;
    endtask

    task automatic set_disp(input logic [OPCODE_W-1:0] op, input logic [DATA_W-1:0] ins,
                            input logic [SRC_CNT-1:0] rdy, input logic [TAG_W-1:0] t0,
                            input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d0,
                            input logic [DATA_W-1:0] d1);
        i_rs_en          = 1'b1;
        i_rs_opcode      = op;
        i_rs_insn        = ins;
        i_rs_iaddr       = {ins[ADDR_W-3:0], 2'b00};
        i_rs_dst_tag     = ins[TAG_W-1:0];
        i_rs_src_rdy     = rdy;
        i_rs_src_tag[0]  = t0;
        i_rs_src_tag[1]  = t1;
        i_rs_src_data[0] = d0;
        i_rs_src_data[1] = d1;
    endtask

    task automatic set_cdb(input int c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        i_cdb_en[c]   = 1'b1;
        i_cdb_tag[c]  = t;
        i_cdb_data[c] = d;
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!o_fu_valid && n < limit) begin
            step();
            n++;
        end
        check("wait_valid", 64'(o_fu_valid), 64'd1);
    endtask

    logic [DATA_W-1:0] fill_order [8];

    initial begin
        // Reset state
        n_rst = 1'b0;
        step();
        step();
        check("rst_valid", 64'(o_fu_valid), 64'd0);
        check("rst_stall", 64'(o_rs_stall), 64'd0);
        check("rst_data", 64'(o_fu_src_data), 64'd0);
        check("rst_payload", 64'({o_fu_opcode, o_fu_insn, o_fu_tag}), 64'd0);
        check("rst_iaddr", 64'(o_fu_iaddr), 64'd0);
        n_rst = 1'b1;
        step();

        // Basic dispatch-to-issue latency
        set_disp(5'd3, 32'h10, 2'b11, 6'd0, 6'd0, 32'h11, 32'h22);
        step();
        idle();
        check("t1_not_yet", 64'(o_fu_valid), 64'd0);
        step();
        check("t1_valid", 64'(o_fu_valid), 64'd1);
        check("t1_opcode", 64'(o_fu_opcode), 64'd3);
        check("t1_src", 64'(o_fu_src_data), 64'h00000022_00000011);
        check("t1_stall", 64'(o_rs_stall), 64'd0);
        step();
        step();

        // Fill all slots, waiting on tags 8..1 in dispatch order
        for (int i = 0; i < 8; i++) begin
            set_disp(5'd1, 32'h100 + 32'(i), 2'b10, 6'(8 - i), 6'd0, 32'h0, 32'h5);
            step();
        end
        check("fill_stall", 64'(o_rs_stall), 64'd1);
        set_disp(5'd2, 32'h1FF, 2'b11, 6'd0, 6'd0, 32'h1, 32'h2);
        step();
        check("full_drop", 64'(o_rs_stall), 64'd1);
        idle();
        i_fu_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_cdb(0, 6'(2 * k + 1), 32'hA0 + 32'(k));
            set_cdb(1, 6'(2 * k + 2), 32'hB0 + 32'(k));
            step();
        end
        idle();
        step();
        step();
        check("age_first", 64'(o_fu_insn), 64'h106);
        fill_order = '{32'h106, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h107};
        i_fu_stall = 1'b0;
        for (int e = 1; e < 8; e++) begin
            step();
            check("age_order", 64'(o_fu_insn), 64'(fill_order[e]));
        end
        step();
        check("age_drained", 64'(o_fu_valid), 64'd0);

        // Output register held under FU stall
        i_fu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_disp(5'd4, 32'h200 + 32'(i), 2'b11, 6'd0, 6'd0, 32'h7, 32'h8);
            step();
        end
        idle();
        step();
        step();
        check("hold_oldest", 64'(o_fu_insn), 64'h200);
        i_fu_stall = 1'b0;
        step();
        check("hold_next1", 64'(o_fu_insn), 64'h201);
        step();
        check("hold_next2", 64'(o_fu_insn), 64'h202);
        step();
        check("hold_empty", 64'(o_fu_valid), 64'd0);

        // CDB match in the dispatch cycle
        set_disp(5'd5, 32'h250, 2'b10, 6'd5, 6'd0, 32'h0, 32'h1);
        set_cdb(0, 6'd5, 32'hAB);
        step();
        idle();
        check("disp_cdb_wait", 64'(o_fu_valid), 64'd0);
        step();
        check("disp_cdb_valid", 64'(o_fu_valid), 64'd1);
        check("disp_cdb_data", 64'(o_fu_src_data), 64'h00000001_000000AB);
        step();

        // Pre-rdy source on tag 0 is never overwritten
        set_disp(5'd6, 32'h260, 2'b01, 6'd0, 6'd9, 32'h12, 32'h0);
        set_cdb(0, 6'd0, 32'hFF);
        step();
        idle();
        set_cdb(0, 6'd0, 32'hFF);
        step();
        idle();
        set_cdb(1, 6'd9, 32'h99);
        step();
        idle();
        wait_valid(5);
        check("pre_rdy_data", 64'(o_fu_src_data), 64'h00000099_00000012);
        step();
        step();

        // Flush with four waiting entries and a stalled output
        i_fu_stall = 1'b1;
        set_disp(5'd7, 32'h300, 2'b11, 6'd0, 6'd0, 32'h3, 32'h4);
        step();
        for (int i = 0; i < 4; i++) begin
            set_disp(5'd7, 32'h310 + 32'(i), 2'b10, 6'd20, 6'd0, 32'h0, 32'h4);
            step();
        end
        idle();
        step();
        check("pre_flush_valid", 64'(o_fu_valid), 64'd1);
        check("pre_flush_insn", 64'(o_fu_insn), 64'h300);
        i_flush = 1'b1;
        set_disp(5'd7, 32'h3FF, 2'b11, 6'd0, 6'd0, 32'h5, 32'h6);
        step();
        idle();
        check("flush_valid", 64'(o_fu_valid), 64'd0);
        check("flush_stall", 64'(o_rs_stall), 64'd0);
        i_fu_stall = 1'b0;
        set_disp(5'd8, 32'h301, 2'b11, 6'd0, 6'd0, 32'h9, 32'hA);
        step();
        idle();
        step();
        check("post_flush_insn", 64'(o_fu_insn), 64'h301);

        // Reset mid-operation
        set_disp(5'd9, 32'h400, 2'b10, 6'd30, 6'd0, 32'h0, 32'h1);
        step();
        idle();
        n_rst = 1'b0;
        step();
        check("midrst_valid", 64'(o_fu_valid), 64'd0);
        check("midrst_data", 64'(o_fu_insn), 64'd0);
        n_rst = 1'b1;
        step();

        // Random traffic
        for (int cyc = 0; cyc < 800; cyc++) begin
            n_rst       = ($urandom_range(0, 399) != 0);
            i_flush     = ($urandom_range(0, 99) == 0);
            i_fu_stall  = ($urandom_range(0, 3) == 0);
            i_rs_en     = ($urandom_range(0, 9) < 6);
            i_rs_opcode = OPCODE_W'($urandom);
            i_rs_insn   = $urandom;
            i_rs_iaddr  = $urandom;
            i_rs_dst_tag = TAG_W'($urandom);
            for (int s = 0; s < SRC_CNT; s++) begin
                i_rs_src_rdy[s]  = ($urandom_range(0, 1) == 1);
                i_rs_src_tag[s]  = TAG_W'($urandom_range(0, 12));
                i_rs_src_data[s] = $urandom;
            end
            for (int c = 0; c < CDB_DEPTH; c++) begin
                i_cdb_en[c]   = ($urandom_range(0, 2) == 0);
                i_cdb_tag[c]  = TAG_W'($urandom_range(0, 12));
                i_cdb_data[c] = $urandom;
            end
            step();
        end
        idle();
        n_rst = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
